// File: rtl/flits_tx_buffer_pkg.sv
// Shared NIC flit definitions plus the transmit buffer FSM encoding.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package flits_tx_buffer_pkg;

    localparam int FLIT_WIDTH        = 32;
    localparam int MAX_PACKET_LENGHT = 8;
    localparam int N_BITS_FLIT_TYPE  = 2;

    typedef logic [N_BITS_FLIT_TYPE-1:0] flit_type_t;

    // Flit type codes, carried in the top N_BITS_FLIT_TYPE bits of each flit.
    localparam flit_type_t BODY_FLIT      = 2'b00;
    localparam flit_type_t HEAD_FLIT      = 2'b01;
    localparam flit_type_t TAIL_FLIT      = 2'b10;
    localparam flit_type_t HEAD_TAIL_FLIT = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SENDING   = 2'd1,
        WAIT_FREE = 2'd2
    } tx_state_t;

    function automatic flit_type_t flit_type(input logic [FLIT_WIDTH-1:0] flit);
        return flit[FLIT_WIDTH-1 -: N_BITS_FLIT_TYPE];
    endfunction

    function automatic logic is_head_type(input logic [FLIT_WIDTH-1:0] flit);
        return (flit_type(flit) == HEAD_FLIT) || (flit_type(flit) == HEAD_TAIL_FLIT);
    endfunction

    function automatic logic is_last_type(input logic [FLIT_WIDTH-1:0] flit);
        return (flit_type(flit) == TAIL_FLIT) || (flit_type(flit) == HEAD_TAIL_FLIT);
    endfunction

endpackage

// File: rtl/flits_tx_buffer_credit_counter.sv
// Saturating up/down credit counter tracking free slots in the router input buffer.
// Latency: count updates on the clock edge after credit_inc/credit_dec; nonzero is combinational from the register.
// Backpressure: none; decrement at zero and increment at N_CREDITS are ignored.
//
// Ports: clk, rst (async active-low), credit_inc (credit returned), credit_dec (flit sent),
//        count (registered credit count), nonzero (count != 0).
module credit_counter #(
    parameter int N_CREDITS     = 4,
    parameter int N_BITS_CREDIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     credit_inc,
    input  logic                     credit_dec,
    output logic [N_BITS_CREDIT-1:0] count,
    output logic                     nonzero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= N_BITS_CREDIT'(N_CREDITS);
        end else begin
            case ({credit_inc, credit_dec})
                2'b10: begin
                    // An excess credit beyond the buffer depth is dropped.
                    if (count != N_BITS_CREDIT'(N_CREDITS)) begin
                        count <= count + N_BITS_CREDIT'(1);
                    end
                end
                2'b01: begin
                    if (count != '0) begin
                        count <= count - N_BITS_CREDIT'(1);
                    end
                end
                default: count <= count;  // none, or return and spend cancel out
            endcase
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/flits_tx_buffer.sv
// NIC transmit flit buffer: latches a whole packet, then serializes it one flit per cycle to the router.
// Latency: grant in the request cycle, first flit valid two cycles later; then 1 flit/cycle.
// Backpressure: stalls on zero credits; new heads wait for the router input buffer to go free.
//
// Ports: clk, rst (async active-low); r_msg_to_pkt_i/g_msg_to_pkt_o request/grant with the
//        packetizer; in_link_i parallel packet (flit 0 in the low bits); out_link_o/is_valid_o
//        registered flit to the router; credit_signal_i slot freed; free_signal_i buffer idle.
module flits_tx_buffer
    import flits_tx_buffer_pkg::*;
#(
    parameter int N_BITS_POINTER = 3,
    parameter int N_CREDITS      = 4,
    parameter int N_BITS_CREDIT  = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    r_msg_to_pkt_i,
    output logic                                    g_msg_to_pkt_o,
    input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i,
    output logic [FLIT_WIDTH-1:0]                   out_link_o,
    output logic                                    is_valid_o,
    input  logic                                    credit_signal_i,
    input  logic                                    free_signal_i
);

    tx_state_t                                     state_q, state_d;
    logic [MAX_PACKET_LENGHT-1:0][FLIT_WIDTH-1:0]  buffer_q;
    logic [N_BITS_POINTER-1:0]                     pointer_q;
    logic                                          vc_busy_q;
    logic [N_BITS_CREDIT-1:0]                      credit_cnt;
    logic                                          credit_nz;
    logic [FLIT_WIDTH-1:0]                         cur_flit;
    logic                                          last_flit;
    logic                                          grant;
    logic                                          send;

    credit_counter #(
        .N_CREDITS     (N_CREDITS),
        .N_BITS_CREDIT (N_BITS_CREDIT)
    ) u_credit_counter (
        .clk        (clk),
        .rst        (rst),
        .credit_inc (credit_signal_i),
        .credit_dec (send),
        .count      (credit_cnt),
        .nonzero    (credit_nz)
    );

    assign cur_flit = buffer_q[pointer_q];
    // A packet ends on its tail marker, or is cut off at the last buffer slot.
    assign last_flit = is_last_type(cur_flit) ||
                       (pointer_q == N_BITS_POINTER'(MAX_PACKET_LENGHT - 1));

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        send    = 1'b0;
        case (state_q)
            IDLE: begin
                grant = r_msg_to_pkt_i;
                // Packets not starting with a head are captured and silently discarded.
                if (r_msg_to_pkt_i && is_head_type(in_link_i[FLIT_WIDTH-1:0])) begin
                    state_d = (!vc_busy_q || free_signal_i) ? SENDING : WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (free_signal_i) begin
                    state_d = SENDING;
                end
            end
            SENDING: begin
                // Decision uses the registered credit count only.
                if (credit_nz) begin
                    send = 1'b1;
                    if (last_flit) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign g_msg_to_pkt_o = grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            buffer_q   <= '0;
            pointer_q  <= '0;
            vc_busy_q  <= 1'b0;
            out_link_o <= '0;
            is_valid_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_valid_o <= send;
            if (grant) begin
                buffer_q  <= in_link_i;
                pointer_q <= '0;
            end else if (send) begin
                pointer_q <= pointer_q + N_BITS_POINTER'(1);
            end
            if (send) begin
                out_link_o <= cur_flit;
            end
            // Sending a head claims the router's VC; that claim beats a same-cycle release.
            if (send && (pointer_q == '0)) begin
                vc_busy_q <= 1'b1;
            end else if (free_signal_i) begin
                vc_busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flits_tx_buffer.sv
module tb_flits_tx_buffer;
    import flits_tx_buffer_pkg::*;

    localparam int FW = FLIT_WIDTH;
    localparam int ML = MAX_PACKET_LENGHT;
    localparam int NC = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             r_msg;
    logic             g_msg;
    logic [ML*FW-1:0] in_link;
    logic [FW-1:0]    out_link;
    logic             is_valid;
    logic             credit_sig;
    logic             free_sig;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    flits_tx_buffer #(
        .N_BITS_POINTER (3),
        .N_CREDITS      (NC),
        .N_BITS_CREDIT  (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .r_msg_to_pkt_i  (r_msg),
        .g_msg_to_pkt_o  (g_msg),
        .in_link_i       (in_link),
        .out_link_o      (out_link),
        .is_valid_o      (is_valid),
        .credit_signal_i (credit_sig),
        .free_signal_i   (free_sig)
    );

    function automatic logic [FW-1:0] mk_flit(input flit_type_t t);
        logic [FW-N_BITS_FLIT_TYPE-1:0] pl;
        pl = (FW-N_BITS_FLIT_TYPE)'($urandom);
        return {t, pl};
    endfunction

    function automatic flit_type_t type_of(input logic [FW-1:0] f);
        return f[FW-1 -: N_BITS_FLIT_TYPE];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst        = 1'b0;
        r_msg      = 1'b0;
        credit_sig = 1'b0;
        free_sig   = 1'b0;
        in_link    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; r_msg = 1'b0; credit_sig = 1'b0; free_sig = 1'b0; in_link = '0;
        #3;
        n_cmp++; if (is_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", is_valid); end
        n_cmp++; if (out_link !== '0) begin n_fail++; $display("FAIL reset_out got %h want 0", out_link); end
        apply_reset;
        #1;
        n_cmp++; if (g_msg !== 1'b0) begin n_fail++; $display("FAIL reset_grant got %0b want 0", g_msg); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", dut.state_q); end
        n_cmp++; if (dut.credit_cnt !== 3'(NC)) begin n_fail++; $display("FAIL reset_credit got %0d want %0d", dut.credit_cnt, NC); end
        n_cmp++; if (dut.vc_busy_q !== 1'b0) begin n_fail++; $display("FAIL reset_vc got %0b want 0", dut.vc_busy_q); end
        n_cmp++; if (dut.pointer_q !== '0) begin n_fail++; $display("FAIL reset_ptr got %0d want 0", dut.pointer_q); end
        step;
    endtask

    task automatic test_head_tail;
        logic [FW-1:0] f0;
        apply_reset;
        f0 = mk_flit(HEAD_TAIL_FLIT);
        in_link[0 +: FW] = f0;
        for (int cyc = 0; cyc <= 3; cyc++) begin
            r_msg = (cyc == 0);
            #1;
            if (cyc == 0) begin
                n_cmp++; if (g_msg !== 1'b1) begin n_fail++; $display("FAIL ht_grant got %0b want 1", g_msg); end
            end
            n_cmp++; if (is_valid !== (cyc == 2)) begin n_fail++; $display("FAIL ht_valid cyc %0d got %0b want %0b", cyc, is_valid, cyc == 2); end
            if (cyc == 2) begin
                n_cmp++; if (out_link !== f0) begin n_fail++; $display("FAIL ht_flit got %h want %h", out_link, f0); end
                n_cmp++; if (dut.credit_cnt !== 3'(NC-1)) begin n_fail++; $display("FAIL ht_credit got %0d want %0d", dut.credit_cnt, NC-1); end
                n_cmp++; if (dut.vc_busy_q !== 1'b1) begin n_fail++; $display("FAIL ht_vc got %0b want 1", dut.vc_busy_q); end
                n_cmp++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL ht_state got %0d want IDLE", dut.state_q); end
            end
            step;
        end
        r_msg = 1'b0;
    endtask

    // Six flits against four credits: four go out, then each returned credit releases one more.
    task automatic test_credit_stall;
        logic [FW-1:0] f [6];
        int exp_idx [16];
        apply_reset;
        for (int i = 0; i < 6; i++) begin
            f[i] = mk_flit((i == 0) ? HEAD_FLIT : (i == 5) ? TAIL_FLIT : BODY_FLIT);
            in_link[i*FW +: FW] = f[i];
        end
        for (int c = 0; c < 16; c++) exp_idx[c] = -1;
        exp_idx[2] = 0; exp_idx[3] = 1; exp_idx[4] = 2; exp_idx[5] = 3;
        exp_idx[10] = 4; exp_idx[14] = 5;
        for (int cyc = 0; cyc < 16; cyc++) begin
            r_msg      = (cyc == 0);
            credit_sig = (cyc == 8) || (cyc == 12);
            #1;
            if (cyc == 0) begin
                n_cmp++; if (g_msg !== 1'b1) begin n_fail++; $display("FAIL cs_grant got %0b want 1", g_msg); end
            end
            n_cmp++; if (is_valid !== (exp_idx[cyc] >= 0)) begin n_fail++; $display("FAIL cs_valid cyc %0d got %0b want %0b", cyc, is_valid, exp_idx[cyc] >= 0); end
            if (exp_idx[cyc] >= 0) begin
                n_cmp++; if (out_link !== f[exp_idx[cyc]]) begin n_fail++; $display("FAIL cs_flit cyc %0d got %h want %h", cyc, out_link, f[exp_idx[cyc]]); end
            end
            if (cyc == 7) begin
                n_cmp++; if (dut.credit_cnt !== 3'd0) begin n_fail++; $display("FAIL cs_credit_zero got %0d want 0", dut.credit_cnt); end
            end
            step;
        end
        credit_sig = 1'b0;
        r_msg = 1'b0;
        n_cmp++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL cs_state got %0d want IDLE", dut.state_q); end
    endtask

    // Follows the credit-stall packet: VC still busy, credits exhausted.
    task automatic test_wait_free;
        logic [FW-1:0] f0;
        for (int k = 0; k < 6; k++) begin
            credit_sig = 1'b1;
            step;
        end
        credit_sig = 1'b0;
        n_cmp++; if (dut.credit_cnt !== 3'(NC)) begin n_fail++; $display("FAIL wf_credit_sat got %0d want %0d", dut.credit_cnt, NC); end
        f0 = mk_flit(HEAD_TAIL_FLIT);
        in_link[0 +: FW] = f0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            r_msg    = (cyc == 0);
            free_sig = (cyc == 10);
            #1;
            if (cyc == 0) begin
                n_cmp++; if (g_msg !== 1'b1) begin n_fail++; $display("FAIL wf_grant got %0b want 1", g_msg); end
            end
            if (cyc == 1) begin
                n_cmp++; if (dut.state_q !== WAIT_FREE) begin n_fail++; $display("FAIL wf_state got %0d want WAIT_FREE", dut.state_q); end
            end
            n_cmp++; if (is_valid !== (cyc == 12)) begin n_fail++; $display("FAIL wf_valid cyc %0d got %0b want %0b", cyc, is_valid, cyc == 12); end
            if (cyc == 12) begin
                n_cmp++; if (out_link !== f0) begin n_fail++; $display("FAIL wf_flit got %h want %h", out_link, f0); end
                n_cmp++; if (dut.vc_busy_q !== 1'b1) begin n_fail++; $display("FAIL wf_vc got %0b want 1", dut.vc_busy_q); end
            end
            step;
        end
        r_msg = 1'b0;
        free_sig = 1'b0;
    endtask

    task automatic test_no_tail;
        logic [FW-1:0] f [ML];
        apply_reset;
        for (int i = 0; i < ML; i++) begin
            f[i] = mk_flit((i == 0) ? HEAD_FLIT : BODY_FLIT);
            in_link[i*FW +: FW] = f[i];
        end
        credit_sig = 1'b1;
        for (int cyc = 0; cyc <= ML + 3; cyc++) begin
            r_msg = (cyc == 0);
            #1;
            n_cmp++; if (is_valid !== (cyc >= 2 && cyc < ML + 2)) begin n_fail++; $display("FAIL nt_valid cyc %0d got %0b", cyc, is_valid); end
            if (cyc >= 2 && cyc < ML + 2) begin
                n_cmp++; if (out_link !== f[cyc-2]) begin n_fail++; $display("FAIL nt_flit cyc %0d got %h want %h", cyc, out_link, f[cyc-2]); end
            end
            if (cyc == ML + 2) begin
                n_cmp++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL nt_state got %0d want IDLE", dut.state_q); end
                n_cmp++; if (dut.credit_cnt !== 3'(NC)) begin n_fail++; $display("FAIL nt_credit got %0d want %0d", dut.credit_cnt, NC); end
            end
            step;
        end
        credit_sig = 1'b0;
        r_msg = 1'b0;
    endtask

    task automatic test_body_head;
        in_link[0 +: FW]  = mk_flit(BODY_FLIT);
        in_link[FW +: FW] = mk_flit(TAIL_FLIT);
        for (int cyc = 0; cyc <= 4; cyc++) begin
            r_msg = (cyc == 0);
            #1;
            if (cyc == 0) begin
                n_cmp++; if (g_msg !== 1'b1) begin n_fail++; $display("FAIL bh_grant got %0b want 1", g_msg); end
            end else begin
                n_cmp++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL bh_state cyc %0d got %0d want IDLE", cyc, dut.state_q); end
            end
            n_cmp++; if (is_valid !== 1'b0) begin n_fail++; $display("FAIL bh_valid cyc %0d got %0b want 0", cyc, is_valid); end
            step;
        end
        n_cmp++; if (dut.credit_cnt !== 3'(NC)) begin n_fail++; $display("FAIL bh_credit got %0d want %0d", dut.credit_cnt, NC); end
    endtask

    task automatic test_reset_mid;
        logic [FW-1:0] f [4];
        logic [FW-1:0] h;
        apply_reset;
        for (int i = 0; i < 4; i++) begin
            f[i] = mk_flit((i == 0) ? HEAD_FLIT : (i == 3) ? TAIL_FLIT : BODY_FLIT);
            in_link[i*FW +: FW] = f[i];
        end
        for (int cyc = 0; cyc <= 3; cyc++) begin
            r_msg = (cyc == 0);
            #1;
            n_cmp++; if (is_valid !== (cyc >= 2)) begin n_fail++; $display("FAIL rm_valid cyc %0d got %0b", cyc, is_valid); end
            if (cyc >= 2) begin
                n_cmp++; if (out_link !== f[cyc-2]) begin n_fail++; $display("FAIL rm_flit cyc %0d got %h want %h", cyc, out_link, f[cyc-2]); end
            end
            if (cyc < 3) step;
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (is_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async_valid got %0b want 0", is_valid); end
        n_cmp++; if (out_link !== '0) begin n_fail++; $display("FAIL rm_async_out got %h want 0", out_link); end
        step;
        step;
        rst = 1'b1;
        #1;
        n_cmp++; if (dut.credit_cnt !== 3'(NC)) begin n_fail++; $display("FAIL rm_credit got %0d want %0d", dut.credit_cnt, NC); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL rm_state got %0d want IDLE", dut.state_q); end
        step;
        h = mk_flit(HEAD_TAIL_FLIT);
        in_link[0 +: FW] = h;
        for (int cyc = 0; cyc <= 3; cyc++) begin
            r_msg = (cyc == 0);
            #1;
            n_cmp++; if (is_valid !== (cyc == 2)) begin n_fail++; $display("FAIL rm_next_valid cyc %0d got %0b", cyc, is_valid); end
            if (cyc == 2) begin
                n_cmp++; if (out_link !== h) begin n_fail++; $display("FAIL rm_next_flit got %h want %h", out_link, h); end
            end
            step;
        end
        r_msg = 1'b0;
    endtask

    // Random packets, credits and frees; flits checked in order against a packet-level
    // scoreboard, and the credit count against plain arithmetic with saturation.
    task automatic test_random;
        logic [FW-1:0] q [$];
        logic [FW-1:0] exp_f;
        logic [FW-1:0] fl;
        flit_type_t    t;
        int            model_cnt;
        logic          prev_credit;
        logic          granted;
        int            u;
        apply_reset;
        model_cnt   = NC;
        prev_credit = 1'b0;
        granted     = 1'b0;
        for (int cyc = 0; cyc < 3400; cyc++) begin
            if (is_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_unexpected_flit got %h want none", out_link);
                end else begin
                    exp_f = q.pop_front();
                    if (out_link !== exp_f) begin n_fail++; $display("FAIL rnd_flit got %h want %h", out_link, exp_f); end
                end
                n_cmp++; if (model_cnt <= 0) begin n_fail++; $display("FAIL rnd_no_credit got send want stall"); end
            end
            model_cnt = model_cnt - (is_valid ? 1 : 0) + (prev_credit ? 1 : 0);
            if (model_cnt > NC) model_cnt = NC;
            n_cmp++; if (int'(dut.credit_cnt) !== model_cnt) begin n_fail++; $display("FAIL rnd_credit got %0d want %0d", dut.credit_cnt, model_cnt); end
            if (granted) r_msg = 1'b0;
            granted = 1'b0;
            if (cyc < 3000) begin
                if (!r_msg && ($urandom_range(0, 2) == 0)) begin
                    for (int i = 0; i < ML; i++) begin
                        u = int'($urandom_range(0, 9));
                        if (i == 0) t = (u < 5) ? HEAD_FLIT : (u < 8) ? HEAD_TAIL_FLIT : (u < 9) ? BODY_FLIT : TAIL_FLIT;
                        else        t = (u < 7) ? BODY_FLIT : (u < 9) ? TAIL_FLIT : HEAD_TAIL_FLIT;
                        in_link[i*FW +: FW] = mk_flit(t);
                    end
                    r_msg = 1'b1;
                end
                credit_sig = 1'($urandom_range(0, 1));
                free_sig   = ($urandom_range(0, 3) == 0);
            end else begin
                credit_sig = 1'b1;
                free_sig   = 1'b1;
                if (q.size() == 0 && !r_msg && !is_valid && dut.state_q == IDLE) break;
            end
            prev_credit = credit_sig;
            #1;
            if (r_msg && g_msg) begin
                granted = 1'b1;
                fl = in_link[0 +: FW];
                if (type_of(fl) == HEAD_FLIT || type_of(fl) == HEAD_TAIL_FLIT) begin
                    for (int i = 0; i < ML; i++) begin
                        fl = in_link[i*FW +: FW];
                        q.push_back(fl);
                        if (type_of(fl) == TAIL_FLIT || type_of(fl) == HEAD_TAIL_FLIT) break;
                    end
                end
            end
            step;
        end
        n_cmp++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got %0d pending want 0", q.size()); end
        r_msg = 1'b0; credit_sig = 1'b0; free_sig = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_head_tail;
        test_credit_stall;
        test_wait_free;
        test_no_tail;
        test_body_head;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
